// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler that time-shares one FIR MAC datapath between N_CH channels.
// Grants are issued combinationally in IDLE; tap sequencing and result handshake are registered.
module fir_channel_scheduler #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned LENGTH = 8,
    parameter int unsigned CSEL_W = 8,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   chan_enable,
    input  logic [N_CH-1:0]   input_valid,
    output logic [N_CH-1:0]   input_ready,
    output logic              load_fir_input,
    output logic              reset_fir_output,
    output logic [CSEL_W-1:0] coef_select,
    output logic [CH_W-1:0]   ch_sel,
    output logic              shift_enable,
    output logic              output_valid,
    input  logic              output_ready,
    output logic [CH_W-1:0]   out_channel,
    output logic              busy
);

    localparam int unsigned PAD = 2 ** CH_W;

    typedef enum logic [1:0] {IDLE, CLEAR, CALC, DONE} state_t;

    state_t          state;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] cand;
    logic            grant_found;
    logic [N_CH-1:0] req;
    logic [PAD-1:0]  req_pad;

    assign req = input_valid & chan_enable;

    // Search starts one past the previous owner so every channel gets a turn.
    always_comb begin
        req_pad     = PAD'(req);
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = CH_W'((32'(last_grant) + i) % N_CH);
            if (!grant_found && req_pad[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Same-cycle strobes; suppressed while reset is pending so nothing leaks out.
    always_comb begin
        input_ready    = '0;
        load_fir_input = 1'b0;
        shift_enable   = 1'b0;
        if (!reset) begin
            if (state == IDLE && grant_found) begin
                input_ready    = N_CH'(1) << grant_idx;
                load_fir_input = 1'b1;
            end
            if (state == DONE && output_ready) begin
                shift_enable = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= CH_W'(N_CH - 1);
            ch_sel           <= '0;
            coef_select      <= '0;
            reset_fir_output <= 1'b0;
            output_valid     <= 1'b0;
            out_channel      <= '0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        ch_sel           <= grant_idx;
                        reset_fir_output <= 1'b1;
                        busy             <= 1'b1;
                        state            <= CLEAR;
                    end
                end
                CLEAR: begin
                    reset_fir_output <= 1'b0;
                    coef_select      <= '0;
                    state            <= CALC;
                end
                CALC: begin
                    if (coef_select == CSEL_W'(LENGTH - 1)) begin
                        coef_select  <= '0;
                        output_valid <= 1'b1;
                        out_channel  <= ch_sel;
                        state        <= DONE;
                    end else begin
                        coef_select <= coef_select + 1'b1;
                    end
                end
                DONE: begin
                    if (output_ready) begin
                        output_valid <= 1'b0;
                        last_grant   <= ch_sel;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
